// File: rtl/tick_generator.sv
// Stopwatch timebase: programmable prescaler plus STAGES cascaded modulo-RATIO counters, all outputs single-cycle enables.
// Define TICK_GEN_SQUARE_EN to add the sq[] square-wave outputs for legacy divider compatibility.
module tick_generator #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BASE_HZ = 100,
  parameter int STAGES  = 3,
  parameter int RATIO   = 10,
  parameter int DIV_W   = $clog2(CLK_HZ / BASE_HZ + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  output logic [STAGES-1:0] tick
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [STAGES-1:0] sq
`endif
);

  localparam int              BASE_DIV  = CLK_HZ / BASE_HZ;
  localparam int              CNT_W     = $clog2(RATIO);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RATIO - 1);

  logic [DIV_W-1:0]  pre_q, pre_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  load_val;
  logic [DIV_W-1:0]  pre_last;
  logic [STAGES-1:0] wrap;
  logic [STAGES-1:0] tick_q;

  // A zero divisor would never wrap; treat it as divide-by-one.
  assign load_val = (div_value == '0) ? DIV_W'(1) : div_value;
  assign pre_last = div_q - DIV_W'(1);
  assign wrap[0]  = run & ~clear & (pre_q == pre_last);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pre_d    = pre_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;

    if (clear) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = (pre_q >= pre_last) ? '0 : pre_q + DIV_W'(1);
    end

    if (div_load) begin
      shadow_d = load_val;
    end

    // A load coinciding with the transfer point takes effect for the period that starts now.
    if (clear | wrap[0]) begin
      if (div_load) begin
        div_d  = load_val;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = shadow_q;
        pend_d = 1'b0;
      end
    end else if (div_load) begin
      pend_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      div_q    <= DIV_RESET;
      shadow_q <= DIV_RESET;
      pend_q   <= 1'b0;
      tick_q   <= '0;
    end else begin
      pre_q    <= pre_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= wrap;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (wrap[k-1]) begin
        cnt_d = (cnt_q >= CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
    end

    assign wrap[k] = wrap[k-1] & (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign tick = tick_q;

`ifdef TICK_GEN_SQUARE_EN
  logic [STAGES-1:0] sq_q;

  // Toggling on the wrap edge lines each sq transition up with the rising edge of its tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= '0;
    end else if (clear) begin
      sq_q <= '0;
    end else begin
      sq_q <= sq_q ^ wrap;
    end
  end

  assign sq = sq_q;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator at CLK_HZ=1000, BASE_HZ=100 (divisor 10), STAGES=3, RATIO=10.
// Cycle n is the interval after the n-th rising edge following reset release; outputs are sampled on the falling edge.
module tb_tick_generator;

  typedef struct packed {
    logic [2:0] tick;
    logic [2:0] sq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       clear;
  logic       div_load;
  logic [3:0] div_value;
  logic [2:0] tick;
`ifdef TICK_GEN_SQUARE_EN
  logic [2:0] sq;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [2:0] sq_model;

  tick_generator #(
    .CLK_HZ (1000),
    .BASE_HZ(100),
    .STAGES (3),
    .RATIO  (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clear    (clear),
    .div_load (div_load),
    .div_value(div_value),
    .tick     (tick)
`ifdef TICK_GEN_SQUARE_EN
    ,
    .sq       (sq)
`endif
  );

  always #5 clk = ~clk;

  // Expected square state follows from the expected ticks alone.
  task automatic push(input logic [2:0] t);
    exp_t e;
    sq_model = sq_model ^ t;
    e.tick   = t;
    e.sq     = sq_model;
    exp_q.push_back(e);
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    run       = 1'b0;
    clear     = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n    = 1'b0;
    sq_model = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_tick got %b want 000", tick);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      run = (n > 15);
      push({1'b0, 1'b0, n == 25});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 1000; n++) begin
      run = 1'b1;
      push({n % 1000 == 0, n % 100 == 0, n % 10 == 0});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL free_run cyc %0d got %b want %b", n, tick, e.tick);
      end
`ifdef TICK_GEN_SQUARE_EN
      checks++;
      if (sq !== e.sq) begin
        errors++;
        $display("FAIL free_run_sq cyc %0d got %b want %b", n, sq, e.sq);
      end
`endif
    end
  endtask

  task automatic test_pause();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      run = !(n >= 15 && n <= 21);
      push({1'b0, 1'b0, (n == 10 || n == 27 || n == 37)});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL pause cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    logic t0;
    do_reset();
    for (int n = 1; n <= 165; n++) begin
      run   = 1'b1;
      clear = (n == 9 || n == 59);
      if (clear) sq_model = '0;
      t0 = (n == 19 || n == 29 || n == 39 || n == 49) || (n >= 69 && (n - 69) % 10 == 0);
      push({1'b0, n == 159, t0});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL clear cyc %0d got %b want %b", n, tick, e.tick);
      end
`ifdef TICK_GEN_SQUARE_EN
      checks++;
      if (sq !== e.sq) begin
        errors++;
        $display("FAIL clear_sq cyc %0d got %b want %b", n, sq, e.sq);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_div_load();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 50; n++) begin
      run       = 1'b1;
      div_load  = (n == 3);
      div_value = 4'd4;
      push({1'b0, n == 46, (n == 10 || (n > 10 && (n - 10) % 4 == 0))});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL div_load cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
    idle_inputs();
  endtask

  // Two loads before the first wrap (last wins), then a load on a wrap edge.
  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      run       = 1'b1;
      div_load  = (n == 2 || n == 5 || n == 16);
      div_value = (n == 2) ? 4'd7 : (n == 5) ? 4'd3 : 4'd5;
      push({1'b0, 1'b0, (n == 10 || n == 13 || n == 16 || n == 21 || n == 26)});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 55; n++) begin
      run       = 1'b1;
      div_load  = (n == 3);
      div_value = 4'd5;
      push({1'b0, n == 55, (n == 10 || (n > 10 && (n - 10) % 5 == 0))});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL async_pre cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
    div_load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tick !== 3'b000) begin
      errors++;
      $display("FAIL async_immediate got %b want 000", tick);
    end
    sq_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      run = 1'b1;
      push({1'b0, 1'b0, n % 10 == 0});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL async_post cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
    // A load still pending when reset hits must be discarded.
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      run       = 1'b1;
      div_load  = (n == 5);
      div_value = 4'd7;
      push(3'b000);
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL async_pend_pre cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
    div_load = 1'b0;
    rst_n    = 1'b0;
    sq_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      run = 1'b1;
      push({1'b0, 1'b0, n % 10 == 0});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL async_pend_post cyc %0d got %b want %b", n, tick, e.tick);
      end
    end
    idle_inputs();
  endtask

  task automatic test_div_zero();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      run       = 1'b1;
      div_load  = (n == 2);
      div_value = 4'd0;
      push({1'b0, (n == 19 || n == 29), n >= 10});
      advance();
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL div_zero cyc %0d got %b want %b", n, tick, e.tick);
      end
`ifdef TICK_GEN_SQUARE_EN
      checks++;
      if (sq !== e.sq) begin
        errors++;
        $display("FAIL div_zero_sq cyc %0d got %b want %b", n, sq, e.sq);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n    = 1'b0;
    sq_model = '0;
    test_reset();
    test_free_run();
    test_pause();
    test_clear();
    test_div_load();
    test_back_to_back();
    test_async_reset();
    test_div_zero();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Parametrised successor to the fixed 10 Hz divider, used as the stopwatch timebase.
- A programmable prescaler produces a base-rate enable. STAGES cascaded modulo-RATIO counters derive slower rates from it, e.g. 100 Hz / 10 Hz / 1 Hz for hundredths, tenths and seconds.
- All outputs are single-cycle clock enables in the clk domain. No derived clocks are produced.
- Adds run/pause, synchronous clear and runtime divisor reload, none of which the legacy divider had.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- BASE_HZ, 100, rate of tick[0]. BASE_DIV = CLK_HZ/BASE_HZ, which must be an integer ≥ 1.
- STAGES, 3, number of tick outputs (≥ 1).
- RATIO, 10, divide factor between tick[k-1] and tick[k] (≥ 2).
- DIV_W, $clog2(BASE_DIV+1), width of the prescaler counter and div_value.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous, active-low reset.
- run, in, 1, count enable. Counters hold while low.
- clear, in, 1, synchronous zeroing of all counters.
- div_load, in, 1, one-cycle strobe that captures div_value.
- div_value, in, DIV_W, new base divisor.
- tick, out, STAGES, registered one-cycle enable pulses. tick[0] is the fastest output.

Behaviour:
- **Reset (rst_n=0, async):**
  - Prescaler and all stage counters go to 0; tick = 0.
  - Active divisor div_q = BASE_DIV; pending-load flag is cleared.
  - On rst_n release, counting starts on the first rising edge.
- **Prescaler:**
  - pre counts 0..div_q-1 on each edge with run=1.
  - wrap0 = run & (pre == div_q-1); on wrap0, pre returns to 0.
- **Stage k (k ≥ 1):**
  - cnt[k] counts 0..RATIO-1, advancing on wrap[k-1].
  - wrap[k] = wrap[k-1] & (cnt[k] == RATIO-1).
- **Tick timing:**
  - tick[k] is registered from wrap[k], so it is high for exactly the one cycle after the wrapping edge.
  - Coincident ticks are all high in the same cycle.
  - With run held high from reset release, the first tick[k] occurs in cycle BASE_DIV·RATIO^k (the first edge after release is cycle 1).
- **run = 0:**
  - All counters hold, no wrap occurs, and tick is 0 the following cycle.
  - Pausing never loses or adds counts: the elapsed count resumes exactly where it stopped.
- **clear = 1:**
  - Takes priority over run and wrap.
  - All counters go to 0, and tick is 0 the next cycle even if a wrap would have occurred.
  - Any pending divisor is applied to div_q immediately.
- **div_load:**
  - div_value is latched into a shadow register and the pending flag is set.
  - The shadow is transferred to div_q at the next prescaler wrap or clear, so the current period always completes with the old divisor.
  - div_value = 0 is stored as 1, giving tick[0] every run cycle.
  - div_load in the same cycle as a wrap: the new value applies from the following period.
  - A second load before the transfer overwrites the shadow; the last one wins.
- **Widths:**
  - Stage counters are $clog2(RATIO) bits.
  - No counter may exceed its modulus. Out-of-range states (e.g. pre ≥ div_q after a transfer) wrap to 0 on the next run edge without asserting tick.

Optional Feature:
- Macro: TICK_GEN_SQUARE_EN.
- When defined, an extra output port sq[STAGES-1:0] is added:
  - sq[k] toggles on each tick[k] pulse, giving a 50% duty square wave at half the tick rate (legacy divider-compatible).
  - Reset value is 0; clear forces it to 0; it holds while run = 0.
- When undefined, the port and its registers are absent and all other behaviour is identical.

Test Plan (CLK_HZ=1000, BASE_HZ=100 → BASE_DIV=10, STAGES=3, RATIO=10):
- Release rst_n, hold run=1 → tick[0] high in cycles 10, 20, 30…; tick[1] first in cycle 100; tick[2] first in cycle 1000, coincident with tick[0] and tick[1].
- run=1, drop run in cycles 15–21 (7 cycles) → no ticks during the pause; next tick[0] in cycle 27.
- clear in cycle 9 (would-be wrap) → no tick in cycle 10; next tick[0] in cycle 19; tick[1] count restarts from 0.
- div_load with div_value=4 in cycle 3 → tick[0] in cycles 10, 14, 18, 22; tick[1] at the 10th tick[0].
- rst_n low in cycle 55 → tick immediately 0, counters 0, div_q reset to 10; after release, first tick[0] 10 cycles later.
- div_value=0 loaded, then run=1 → after the current period completes, tick[0] is high every cycle; with TICK_GEN_SQUARE_EN, sq[0] toggles each cycle.
